// File: rtl/ahb_write_buffer.sv
// Posted-write buffer: accepts AHB-Lite writes into a FIFO with zero wait states
// and drains them downstream as SINGLE transfers; reads wait for an empty FIFO.
module ahb_write_buffer #(
  parameter int W_ADDR = 32,
  parameter int W_DATA = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              src_hready_resp,
  output logic              src_hresp,
  output logic [W_DATA-1:0] src_hrdata,
  input  logic              src_hready,
  input  logic [W_ADDR-1:0] src_haddr,
  input  logic              src_hwrite,
  input  logic [1:0]        src_htrans,
  input  logic [2:0]        src_hsize,
  input  logic [2:0]        src_hburst,
  input  logic [3:0]        src_hprot,
  input  logic              src_hmastlock,
  input  logic [W_DATA-1:0] src_hwdata,
  input  logic              dst_hready_resp,
  input  logic              dst_hresp,
  input  logic [W_DATA-1:0] dst_hrdata,
  output logic              dst_hready,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic              dst_hwrite,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [2:0]        dst_hburst,
  output logic [3:0]        dst_hprot,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata,
  output logic              write_err,
  input  logic              err_clr
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [DEPTH:0] FULL_CNT = (DEPTH+1)'(DEPTH);
  localparam logic [DEPTH:0] CNT_ONE  = (DEPTH+1)'(1);

  typedef enum logic [2:0] {U_IDLE, U_WDATA, U_RWAIT, U_RDONE, U_ERR0, U_ERR1} ustate_t;
  typedef enum logic [2:0] {D_IDLE, D_WA, D_WD, D_RA, D_RD} dstate_t;

  ustate_t u_state, u_next;
  dstate_t d_state, d_next;

  logic [W_ADDR-1:0] cap_addr;
  logic [2:0]        cap_size;
  logic [3:0]        cap_prot;

  logic [W_ADDR-1:0] fifo_addr [DEPTH];
  logic [2:0]        fifo_size [DEPTH];
  logic [3:0]        fifo_prot [DEPTH];
  logic [W_DATA-1:0] fifo_data [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [DEPTH:0]    count;

  logic addr_ph, push, pop;
  logic load_wr, load_rd, rd_ok, rd_err, err_set;
  ustate_t follow;

  logic unused_ok;
  assign unused_ok = ^{src_htrans[0], src_hburst, src_hmastlock};

  assign addr_ph = src_hready && src_htrans[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_addr <= '0;
      cap_size <= '0;
      cap_prot <= '0;
    end else if (addr_ph) begin
      cap_addr <= src_haddr;
      cap_size <= src_hsize;
      cap_prot <= src_hprot;
    end
  end

  // Upstream FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) u_state <= U_IDLE;
    else        u_state <= u_next;
  end

  always_comb begin
    u_next          = u_state;
    src_hready_resp = 1'b1;
    src_hresp       = 1'b0;
    push            = 1'b0;
    follow          = addr_ph ? (src_hwrite ? U_WDATA : U_RWAIT) : U_IDLE;
    case (u_state)
      U_IDLE:  u_next = follow;
      U_WDATA: begin
        src_hready_resp = (count != FULL_CNT);
        if (count != FULL_CNT) begin
          push   = 1'b1;
          u_next = follow;
        end
      end
      U_RWAIT: begin
        src_hready_resp = 1'b0;
        if (rd_ok)       u_next = U_RDONE;
        else if (rd_err) u_next = U_ERR0;
      end
      U_RDONE: u_next = follow;
      U_ERR0: begin
        src_hready_resp = 1'b0;
        src_hresp       = 1'b1;
        u_next          = U_ERR1;
      end
      U_ERR1: begin
        src_hresp = 1'b1;
        u_next    = follow;
      end
      default: u_next = U_IDLE;
    endcase
  end

  // FIFO storage carries no reset; pointers and count alone define its contents
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= cap_addr;
      fifo_size[wr_ptr] <= cap_size;
      fifo_prot[wr_ptr] <= cap_prot;
      fifo_data[wr_ptr] <= src_hwdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

  // Downstream FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) d_state <= D_IDLE;
    else        d_state <= d_next;
  end

  always_comb begin
    d_next  = d_state;
    load_wr = 1'b0;
    load_rd = 1'b0;
    pop     = 1'b0;
    rd_ok   = 1'b0;
    rd_err  = 1'b0;
    err_set = 1'b0;
    case (d_state)
      D_IDLE: begin
        if (count != '0) begin
          load_wr = 1'b1;
          d_next  = D_WA;
        end else if (u_state == U_RWAIT) begin
          load_rd = 1'b1;
          d_next  = D_RA;
        end
      end
      D_WA: if (dst_hready_resp) d_next = D_WD;
      D_WD: begin
        if (dst_hready_resp) begin
          pop     = 1'b1;
          err_set = dst_hresp;
          d_next  = D_IDLE;
        end
      end
      D_RA: if (dst_hready_resp) d_next = D_RD;
      D_RD: begin
        if (dst_hready_resp) begin
          rd_ok  = !dst_hresp;
          rd_err = dst_hresp;
          d_next = D_IDLE;
        end
      end
      default: d_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_haddr  <= '0;
      dst_hsize  <= '0;
      dst_hprot  <= '0;
      dst_hwrite <= 1'b0;
      dst_hwdata <= '0;
    end else if (load_wr) begin
      dst_haddr  <= fifo_addr[rd_ptr];
      dst_hsize  <= fifo_size[rd_ptr];
      dst_hprot  <= fifo_prot[rd_ptr];
      dst_hwrite <= 1'b1;
      dst_hwdata <= fifo_data[rd_ptr];
    end else if (load_rd) begin
      dst_haddr  <= cap_addr;
      dst_hsize  <= cap_size;
      dst_hprot  <= cap_prot;
      dst_hwrite <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     src_hrdata <= '0;
    else if (rd_ok) src_hrdata <= dst_hrdata;
  end

  // A new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       write_err <= 1'b0;
    else if (err_set) write_err <= 1'b1;
    else if (err_clr) write_err <= 1'b0;
  end

  assign dst_htrans    = (d_state == D_WA || d_state == D_RA) ? 2'b10 : 2'b00;
  assign dst_hready    = dst_hready_resp;
  assign dst_hburst    = 3'b000;
  assign dst_hmastlock = 1'b0;

endmodule

// File: tb/tb_ahb_write_buffer.sv
// Scoreboard bench for ahb_write_buffer: an upstream master driver, a downstream
// slave responder and queues of expected upstream/downstream transfers.
module tb_ahb_write_buffer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        src_hready_resp, src_hresp;
  logic [31:0] src_hrdata;
  logic        src_hready;
  logic [31:0] src_haddr;
  logic        src_hwrite;
  logic [1:0]  src_htrans;
  logic [2:0]  src_hsize, src_hburst;
  logic [3:0]  src_hprot;
  logic        src_hmastlock;
  logic [31:0] src_hwdata;
  logic        dst_hready_resp, dst_hresp;
  logic [31:0] dst_hrdata;
  logic        dst_hready;
  logic [31:0] dst_haddr;
  logic        dst_hwrite;
  logic [1:0]  dst_htrans;
  logic [2:0]  dst_hsize, dst_hburst;
  logic [3:0]  dst_hprot;
  logic        dst_hmastlock;
  logic [31:0] dst_hwdata;
  logic        write_err, err_clr;

  ahb_write_buffer #(.W_ADDR(32), .W_DATA(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .src_hready_resp(src_hready_resp), .src_hresp(src_hresp), .src_hrdata(src_hrdata),
    .src_hready(src_hready), .src_haddr(src_haddr), .src_hwrite(src_hwrite),
    .src_htrans(src_htrans), .src_hsize(src_hsize), .src_hburst(src_hburst),
    .src_hprot(src_hprot), .src_hmastlock(src_hmastlock), .src_hwdata(src_hwdata),
    .dst_hready_resp(dst_hready_resp), .dst_hresp(dst_hresp), .dst_hrdata(dst_hrdata),
    .dst_hready(dst_hready), .dst_haddr(dst_haddr), .dst_hwrite(dst_hwrite),
    .dst_htrans(dst_htrans), .dst_hsize(dst_hsize), .dst_hburst(dst_hburst),
    .dst_hprot(dst_hprot), .dst_hmastlock(dst_hmastlock), .dst_hwdata(dst_hwdata),
    .write_err(write_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;
  assign src_hready = src_hready_resp;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } op_t;

  op_t ops[$];
  op_t dst_q[$];
  op_t ap, dp;
  logic ap_valid = 1'b0, dp_valid = 1'b0;
  int   dp_cycles = 0;

  int tests = 0, fails = 0;
  int cyc = 0, stall_cnt = 0, last_rd_lat = 0, last_wr_done_cyc = 0;
  int first_pop_cyc = -1, dst_wr_done = 0, dst_accepts = 0;
  logic prev_hr = 1'b1, prev_hresp = 1'b0;

  // downstream slave model
  logic        dph = 1'b0, derr = 1'b0;
  int          dcyc = 0;
  logic [31:0] ph_addr;
  logic        ph_wr;
  logic        hold_low = 1'b0, err_en = 1'b0, clr_on_err = 1'b0, err_clr_man = 1'b0;
  logic [31:0] err_addr = '0, rd_value = '0;

  task automatic enq(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                     input logic err);
    op_t o;
    o.wr = wr; o.addr = addr; o.data = data; o.err = err;
    ops.push_back(o);
    dst_q.push_back(o);
  endtask

  task automatic step();
    op_t  e;
    logic d_done, d_accept;
    @(negedge clk);
    cyc++;
    if (dp_valid) begin
      dp_cycles++;
      if (src_hready_resp) begin
        if (dp.wr) begin
          tests++;
          if (src_hresp !== 1'b0) begin
            fails++;
            $display("[TB] FAIL up_write_resp addr=%h got hresp=%b expected 0", dp.addr, src_hresp);
          end
          last_wr_done_cyc = cyc;
        end else begin
          tests++;
          if (src_hresp !== dp.err) begin
            fails++;
            $display("[TB] FAIL up_read_resp addr=%h got hresp=%b expected %b", dp.addr, src_hresp, dp.err);
          end
          if (dp.err) begin
            tests++;
            if ({prev_hr, prev_hresp} !== 2'b01) begin
              fails++;
              $display("[TB] FAIL up_err_first_cycle got hready,hresp=%b%b expected 01", prev_hr, prev_hresp);
            end
          end else begin
            tests++;
            if (src_hrdata !== dp.data) begin
              fails++;
              $display("[TB] FAIL up_read_data addr=%h got %h expected %h", dp.addr, src_hrdata, dp.data);
            end
          end
          last_rd_lat = dp_cycles;
        end
        dp_valid = 1'b0;
      end
    end
    if (!src_hready_resp) stall_cnt++;
    if (ap_valid && src_hready_resp) begin
      dp = ap; dp_valid = 1'b1; dp_cycles = 0; ap_valid = 1'b0;
    end
    prev_hr = src_hready_resp;
    prev_hresp = src_hresp;

    d_done   = dph && dst_hready_resp;
    d_accept = (dst_htrans == 2'b10) && dst_hready_resp;
    if (d_done) begin
      tests++;
      if (dst_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL dst_unexpected got addr=%h wr=%b expected no transfer", ph_addr, ph_wr);
      end else begin
        e = dst_q.pop_front();
        if (ph_addr !== e.addr || ph_wr !== e.wr || (e.wr && dst_hwdata !== e.data) ||
            dst_hsize !== 3'b010 || dst_hprot !== 4'b0011) begin
          fails++;
          $display("[TB] FAIL dst_xfer got addr=%h wr=%b data=%h size=%h prot=%h expected addr=%h wr=%b data=%h size=2 prot=3",
                   ph_addr, ph_wr, dst_hwdata, dst_hsize, dst_hprot, e.addr, e.wr, e.data);
        end
      end
      if (ph_wr) begin
        dst_wr_done++;
        if (first_pop_cyc < 0) first_pop_cyc = cyc;
      end
    end
    if (d_accept) begin
      dst_accepts++;
      ph_addr = dst_haddr;
      ph_wr   = dst_hwrite;
    end

    @(posedge clk);
    #1;
    if (d_done) dph = 1'b0;
    if (d_accept) begin
      dph = 1'b1; dcyc = 0; derr = err_en && (ph_addr == err_addr);
    end
    if (dph && derr) begin
      dst_hready_resp = (dcyc != 0);
      dst_hresp       = 1'b1;
    end else begin
      dst_hready_resp = !hold_low;
      dst_hresp       = 1'b0;
    end
    err_clr    = err_clr_man || (clr_on_err && dph && derr && dcyc != 0);
    dst_hrdata = rd_value;
    if (dph) dcyc++;

    if (!ap_valid && ops.size() > 0) begin
      ap = ops.pop_front();
      ap_valid = 1'b1;
    end
    src_htrans = ap_valid ? 2'b10 : 2'b00;
    src_haddr  = ap_valid ? ap.addr : '0;
    src_hwrite = ap_valid ? ap.wr : 1'b0;
    src_hwdata = (dp_valid && dp.wr) ? dp.data : '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((ops.size() != 0 || ap_valid || dp_valid || dst_q.size() != 0 || dph) && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) begin
      tests++; fails++;
      $display("[TB] FAIL drain_timeout got %0d pending ops, %0d pending dst expected 0", ops.size(), dst_q.size());
    end
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    src_haddr = '0; src_hwrite = 1'b0; src_htrans = 2'b00; src_hsize = 3'b010;
    src_hburst = 3'b000; src_hprot = 4'b0011; src_hmastlock = 1'b0; src_hwdata = '0;
    dst_hready_resp = 1'b1; dst_hresp = 1'b0; dst_hrdata = '0; err_clr = 1'b0;
    repeat (3) step();
    tests++;
    if ({src_hready_resp, src_hresp, src_hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("[TB] FAIL reset_src got ready=%b resp=%b rdata=%h expected 1 0 0", src_hready_resp, src_hresp, src_hrdata);
    end
    tests++;
    if ({dst_htrans, dst_haddr, dst_hwrite, dst_hsize, dst_hprot, dst_hwdata} !== '0) begin
      fails++;
      $display("[TB] FAIL reset_dst got trans=%b addr=%h wr=%b size=%h prot=%h wdata=%h expected all 0",
               dst_htrans, dst_haddr, dst_hwrite, dst_hsize, dst_hprot, dst_hwdata);
    end
    tests++;
    if ({write_err, dst_hburst, dst_hmastlock} !== '0 || dst_hready !== dst_hready_resp) begin
      fails++;
      $display("[TB] FAIL reset_misc got err=%b burst=%b lock=%b hready=%b expected 0 000 0 %b",
               write_err, dst_hburst, dst_hmastlock, dst_hready, dst_hready_resp);
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    int wr0 = dst_wr_done;
    stall_cnt = 0;
    for (int i = 0; i < 4; i++) enq(1'b1, 32'h10 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0);
    drain();
    tests++;
    if (stall_cnt !== 0) begin
      fails++;
      $display("[TB] FAIL b2b_no_stall got %0d stall cycles expected 0", stall_cnt);
    end
    tests++;
    if (dst_wr_done - wr0 !== 4) begin
      fails++;
      $display("[TB] FAIL b2b_dst_count got %0d expected 4", dst_wr_done - wr0);
    end
  endtask

  task automatic test_full();
    int wr0 = dst_wr_done;
    stall_cnt = 0;
    first_pop_cyc = -1;
    hold_low = 1'b1;
    for (int i = 0; i < 5; i++) enq(1'b1, 32'h20 + 32'(4 * i), 32'hB0 + 32'(i), 1'b0);
    repeat (10) step();
    tests++;
    if (stall_cnt == 0 || dst_wr_done != wr0) begin
      fails++;
      $display("[TB] FAIL full_stall got stalls=%0d pops=%0d expected stalls>0 pops=0", stall_cnt, dst_wr_done - wr0);
    end
    hold_low = 1'b0;
    drain();
    tests++;
    if (last_wr_done_cyc !== first_pop_cyc + 1) begin
      fails++;
      $display("[TB] FAIL full_release got cycle %0d expected %0d", last_wr_done_cyc, first_pop_cyc + 1);
    end
    tests++;
    if (dst_wr_done - wr0 !== 5) begin
      fails++;
      $display("[TB] FAIL full_dst_count got %0d expected 5", dst_wr_done - wr0);
    end
  endtask

  task automatic test_read_after_write();
    rd_value = 32'h1234;
    enq(1'b1, 32'h40, 32'h1234, 1'b0);
    enq(1'b0, 32'h40, 32'h1234, 1'b0);
    drain();
    tests++;
    if (last_rd_lat !== 7) begin
      fails++;
      $display("[TB] FAIL raw_read_wait got %0d cycles expected 7", last_rd_lat);
    end
    enq(1'b0, 32'h40, 32'h1234, 1'b0);
    drain();
    tests++;
    if (last_rd_lat !== 4) begin
      fails++;
      $display("[TB] FAIL read_latency got %0d cycles expected 4", last_rd_lat);
    end
  endtask

  task automatic test_write_err();
    err_en = 1'b1; err_addr = 32'h80;
    enq(1'b1, 32'h80, 32'hDEAD, 1'b0);
    drain();
    tests++;
    if (write_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL write_err_set got %b expected 1", write_err);
    end
    err_clr_man = 1'b1;
    step();
    err_clr_man = 1'b0;
    step();
    tests++;
    if (write_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL write_err_clear got %b expected 0", write_err);
    end
    clr_on_err = 1'b1; err_addr = 32'h84;
    enq(1'b1, 32'h84, 32'hBEEF, 1'b0);
    drain();
    tests++;
    if (write_err !== 1'b1) begin
      fails++;
      $display("[TB] FAIL write_err_wins got %b expected 1", write_err);
    end
    clr_on_err = 1'b0; err_en = 1'b0;
  endtask

  task automatic test_read_err();
    err_clr_man = 1'b1;
    repeat (2) step();
    err_clr_man = 1'b0;
    err_en = 1'b1; err_addr = 32'h90;
    enq(1'b0, 32'h90, 32'h0, 1'b1);
    enq(1'b1, 32'h94, 32'h55, 1'b0);
    drain();
    tests++;
    if (write_err !== 1'b0) begin
      fails++;
      $display("[TB] FAIL read_err_not_sticky got %b expected 0", write_err);
    end
    err_en = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    int acc0;
    hold_low = 1'b1;
    for (int i = 0; i < 3; i++) enq(1'b1, 32'h60 + 32'(4 * i), 32'hC0 + 32'(i), 1'b0);
    repeat (6) step();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({src_hready_resp, src_hresp, src_hrdata} !== {1'b1, 1'b0, 32'h0}) begin
      fails++;
      $display("[TB] FAIL mid_reset_src got ready=%b resp=%b rdata=%h expected 1 0 0", src_hready_resp, src_hresp, src_hrdata);
    end
    tests++;
    if ({dst_htrans, dst_haddr, dst_hwrite, dst_hsize, dst_hprot, dst_hwdata, write_err} !== '0) begin
      fails++;
      $display("[TB] FAIL mid_reset_dst got trans=%b addr=%h wr=%b wdata=%h err=%b expected all 0",
               dst_htrans, dst_haddr, dst_hwrite, dst_hwdata, write_err);
    end
    ops.delete(); dst_q.delete();
    ap_valid = 1'b0; dp_valid = 1'b0; dph = 1'b0; hold_low = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    acc0 = dst_accepts;
    repeat (20) step();
    tests++;
    if (dst_accepts !== acc0) begin
      fails++;
      $display("[TB] FAIL post_reset_quiet got %0d dst transfers expected 0", dst_accepts - acc0);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_full();
    test_read_after_write();
    test_write_err();
    test_read_err();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
